kmeans_sweep: RTL

//  Upstream driver for the kmeans HLS component. One sweep issues one kmeans call per point idx 0..N-1,

---
 rtl/kmeans_sweep_pkg.sv | 20 ++
 rtl/kmeans_tag_fifo.sv | 54 +++++
 rtl/kmeans_sweep.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/kmeans_sweep_pkg.sv
// rtl/kmeans_sweep_pkg.sv - shared state type, defaults and helpers for the kmeans sweep driver
package kmeans_sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_MAX_CLUSTERS    = 16;
  localparam int DEF_CLUSTER_W       = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_COUNT_W         = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kmeans_tag_fifo.sv
// rtl/kmeans_tag_fifo.sv - tag FIFO pairing outstanding kmeans calls with their point idx
module kmeans_tag_fifo
  import kmeans_sweep_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // a pop frees the slot that a simultaneous push into a full FIFO needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kmeans_sweep.sv
// rtl/kmeans_sweep.sv - sweeps point idx through kmeans, tags returns, streams assignments, keeps histogram
module kmeans_sweep
  import kmeans_sweep_pkg::*;
#(
  parameter int MAX_CLUSTERS    = DEF_MAX_CLUSTERS,
  parameter int CLUSTER_W       = DEF_CLUSTER_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int COUNT_W         = DEF_COUNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [31:0]          cfg_num_points,
  input  logic [31:0]          cfg_num_clusters,
  input  logic [31:0]          cfg_num_dim,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic                 sweep_error,
  output logic                 km_start,
  input  logic                 km_busy,
  output logic [31:0]          km_idx,
  output logic [31:0]          km_num_clusters,
  output logic [31:0]          km_num_dim,
  input  logic                 km_done,
  output logic                 km_stall,
  input  logic [31:0]          km_returndata,
  output logic                 asg_valid,
  input  logic                 asg_ready,
  output logic [31:0]          asg_idx,
  output logic [CLUSTER_W-1:0] asg_cluster,
  input  logic [CLUSTER_W-1:0] hist_rd_addr,
  output logic [COUNT_W-1:0]   hist_rd_data
);

  state_t               state, state_next;
  logic [31:0]          num_points;
  logic [31:0]          num_clusters;
  logic [31:0]          num_dim;
  logic [31:0]          issue_idx;
  logic [COUNT_W-1:0]   hist [MAX_CLUSTERS];
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [31:0]          fifo_head;
  logic                 cfg_invalid;
  logic                 start_accept;
  logic                 call_accept;
  logic                 ret_accept;
  logic                 ret_oob;
  logic [CLUSTER_W-1:0] ret_cluster;

  assign cfg_invalid     = (cfg_num_clusters == 32'd0) || (cfg_num_clusters > 32'(MAX_CLUSTERS));
  assign start_accept    = (state == IDLE) && cfg_start;
  assign sweep_busy      = (state != IDLE);
  assign km_start        = (state == RUN) && (issue_idx < num_points) && !fifo_full;
  assign km_idx          = issue_idx;
  assign km_num_clusters = num_clusters;
  assign km_num_dim      = num_dim;
  assign call_accept     = km_start && !km_busy;
  assign km_stall        = asg_valid && !asg_ready;
  // a return with nothing outstanding is spurious and never popped
  assign ret_accept      = km_done && !km_stall && !fifo_empty;
  assign ret_cluster     = km_returndata[CLUSTER_W-1:0];
  assign ret_oob         = (km_returndata >= num_clusters);

  kmeans_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (call_accept),
    .push_data (issue_idx),
    .pop       (ret_accept),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sweep_done = 1'b0;
    case (state)
      IDLE:    if (cfg_start) state_next = cfg_invalid ? DONE : RUN;
      RUN:     if (issue_idx == num_points) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !asg_valid) state_next = DONE;
      DONE: begin
        sweep_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      num_points   <= '0;
      num_clusters <= '0;
      num_dim      <= '0;
      issue_idx    <= '0;
      asg_valid    <= 1'b0;
      asg_idx      <= '0;
      asg_cluster  <= '0;
      sweep_error  <= 1'b0;
      hist_rd_data <= '0;
      for (int i = 0; i < MAX_CLUSTERS; i++) hist[i] <= '0;
    end else begin
      hist_rd_data <= hist[hist_rd_addr];

      if (start_accept) begin
        num_points   <= cfg_num_points;
        num_clusters <= cfg_num_clusters;
        num_dim      <= cfg_num_dim;
        issue_idx    <= '0;
        for (int i = 0; i < MAX_CLUSTERS; i++) hist[i] <= '0;
      end else if (ret_accept && !ret_oob && (hist[ret_cluster] != {COUNT_W{1'b1}})) begin
        hist[ret_cluster] <= hist[ret_cluster] + 1'b1;
      end

      if (call_accept) issue_idx <= issue_idx + 32'd1;

      if (ret_accept) begin
        asg_valid   <= 1'b1;
        asg_idx     <= fifo_head;
        asg_cluster <= ret_cluster;
      end else if (asg_ready) begin
        asg_valid   <= 1'b0;
      end

      // start clears the sticky flag; faults in the same cycle still win
      if (start_accept) sweep_error <= cfg_invalid;
      if ((km_done && fifo_empty) || (ret_accept && ret_oob)) sweep_error <= 1'b1;
    end
  end

endmodule
